// File: rtl/pipelined_cla_subtractor_pkg.sv
// ============================================================================
// pipelined_cla_subtractor_pkg : slice width and stage-count helper shared by
// the pipelined lookahead subtractor.        Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package pipelined_cla_subtractor_pkg;

   localparam int SLICE_W = 4;

   function automatic int stage_count(input int numbits);
      return numbits / SLICE_W;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_cla_subtractor_slice4.sv
// ============================================================================
// cla_sub_slice4 : combinational 4-bit lookahead subtract slice (a + ~b + ~bw).
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_sub_slice4
   import pipelined_cla_subtractor_pkg::*;
(
   input  logic [SLICE_W-1:0] i_a,
   input  logic [SLICE_W-1:0] i_b,
   input  logic               i_bw,
   output logic [SLICE_W-1:0] o_d,
   output logic               o_bw,
   output logic               o_c3
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g = i_a & ~i_b;
   assign w_p = i_a ^ ~i_b;

   // Borrow-in maps to an inverted carry-in; borrow-out is the inverted carry-out.
   assign w_c[0] = ~i_bw;
   assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

   assign o_d  = w_p ^ w_c[3:0];
   assign o_bw = ~w_c[4];
   assign o_c3 = w_c[3];

endmodule

`default_nettype wire

// File: rtl/pipelined_cla_subtractor.sv
// ============================================================================
// pipelined_cla_subtractor : NUMBITS/4-stage skewed lookahead subtractor with
// valid/ready flow control. Define PIPE_SUB_OVF_EN to add ovf_out. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipelined_cla_subtractor
   import pipelined_cla_subtractor_pkg::*;
#(
   parameter int NUMBITS = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUMBITS-1:0] a_in,
   input  logic [NUMBITS-1:0] b_in,
   input  logic               bw_in,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [NUMBITS-1:0] d_out,
   output logic               bw_out,
   output logic               out_valid,
`ifdef PIPE_SUB_OVF_EN
   output logic               ovf_out,
`endif
   input  logic               out_ready
);

   localparam int STAGES = stage_count(NUMBITS);

   generate
      if (((NUMBITS % SLICE_W) != 0) || (NUMBITS < SLICE_W)) begin : g_bad_width
         $error("NUMBITS must be a positive multiple of 4");
      end
   endgenerate

   // Each rank carries the full word: upper operand slices still pending and
   // lower result slices already resolved, so one transaction stays aligned.
   logic [NUMBITS-1:0] r_a [STAGES];
   logic [NUMBITS-1:0] r_b [STAGES];
   logic [NUMBITS-1:0] r_d [STAGES];
   logic [STAGES-1:0]  r_v;
   logic [STAGES-1:0]  r_bw;

   logic [NUMBITS-1:0] w_sa [STAGES];
   logic [NUMBITS-1:0] w_sb [STAGES];
   logic [NUMBITS-1:0] w_sd [STAGES];
   logic [NUMBITS-1:0] w_nd [STAGES];
   logic [STAGES-1:0]  w_sbw;
   logic [STAGES-1:0]  w_sv;
   logic [STAGES-1:0]  w_nbw;
   logic [STAGES-1:0]  w_c3;
   logic               w_adv;
   logic               w_unused_c3;

   assign w_adv       = out_ready | ~r_v[STAGES-1];
   assign in_ready    = w_adv;
   assign w_unused_c3 = ^w_c3;

   generate
      for (genvar k = 0; k < STAGES; k++) begin : g_stage
         logic [SLICE_W-1:0] w_diff;

         if (k == 0) begin : g_first
            assign w_sa[k]  = a_in;
            assign w_sb[k]  = b_in;
            assign w_sd[k]  = '0;
            assign w_sbw[k] = bw_in;
            assign w_sv[k]  = in_valid;
         end else begin : g_next
            assign w_sa[k]  = r_a[k-1];
            assign w_sb[k]  = r_b[k-1];
            assign w_sd[k]  = r_d[k-1];
            assign w_sbw[k] = r_bw[k-1];
            assign w_sv[k]  = r_v[k-1];
         end

         cla_sub_slice4 u_slice (
            .i_a  (w_sa[k][k*SLICE_W +: SLICE_W]),
            .i_b  (w_sb[k][k*SLICE_W +: SLICE_W]),
            .i_bw (w_sbw[k]),
            .o_d  (w_diff),
            .o_bw (w_nbw[k]),
            .o_c3 (w_c3[k])
         );

         assign w_nd[k] = w_sd[k] | (NUMBITS'(w_diff) << (k*SLICE_W));
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_d[k] <= '0;
         end
         r_v  <= '0;
         r_bw <= '0;
      end else if (w_adv) begin
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= w_sa[k];
            r_b[k] <= w_sb[k];
            r_d[k] <= w_nd[k];
         end
         r_v  <= w_sv;
         r_bw <= w_nbw;
      end
   end

   assign d_out     = r_d[STAGES-1];
   assign bw_out    = r_bw[STAGES-1];
   assign out_valid = r_v[STAGES-1];

`ifdef PIPE_SUB_OVF_EN
   logic r_ovf;

   // Signed overflow: carry into the MSB differs from the carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_adv) begin
         r_ovf <= w_c3[STAGES-1] ^ ~w_nbw[STAGES-1];
      end
   end

   assign ovf_out = r_ovf;
`endif

endmodule

`default_nettype wire
